// File: rtl/csa_pkg.sv
// Shared types and constants for the serial carry-skip adder.
package csa_pkg;

  localparam int BLK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_state_e;

  // Block index needs at least one bit even when there is a single block.
  function automatic int csa_idx_w(input int nblk);
    if (nblk > 1) begin
      return $clog2(nblk);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/csa_prop_gen4.sv
// 4-bit propagate generator: bitwise propagate vector and block propagate.
module csa_prop_gen4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  output logic [3:0] p,
  output logic       bp
);

  assign p  = a4 ^ b4;
  assign bp = &p;

endmodule

// File: rtl/csa_skip_block4.sv
// One 4-bit carry-skip block: ripple chain plus a skip mux on the block carry.
module csa_skip_block4
  import csa_pkg::*;
(
  input  logic [BLK_W-1:0] a4,
  input  logic [BLK_W-1:0] b4,
  input  logic             ci,
  output logic [BLK_W-1:0] s4,
  output logic             co,
  output logic             bp
);

  logic [BLK_W-1:0] p_s;
  logic [BLK_W-1:0] g_s;
  logic [BLK_W:0]   c_s;

  csa_prop_gen4 u_pg (
    .a4 (a4),
    .b4 (b4),
    .p  (p_s),
    .bp (bp)
  );

  assign g_s = a4 & b4;

  // Ripple chain; when every bit propagates the carry-in bypasses the chain.
  always_comb begin
    c_s    = '0;
    c_s[0] = ci;
    for (int i = 0; i < BLK_W; i++) begin
      c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
    end
    s4 = p_s ^ c_s[BLK_W-1:0];
    if (bp) begin
      co = ci;
    end else begin
      co = c_s[BLK_W];
    end
  end

endmodule

// File: rtl/csa_serial_skip_adder.sv
// Multi-cycle carry-skip adder, one 4-bit block per clock, LSB block first.
// Optional skip statistics output enabled by defining CSA_SKIP_STATS_EN.
module csa_serial_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_SKIP_STATS_EN
  ,
  output logic [$clog2(WIDTH/BLK_W+1)-1:0] skip_cnt
`endif
);

  localparam int NBLK  = WIDTH / BLK_W;
  localparam int IDX_W = csa_idx_w(NBLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

  csa_state_e       state_r;
  csa_state_e       state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             accept_s;
  logic             last_s;
  logic             release_s;
  logic [BLK_W-1:0] a_blk_s;
  logic [BLK_W-1:0] b_blk_s;
  logic [BLK_W-1:0] s_blk_s;
  logic             co_blk_s;
  logic             bp_blk_s;

  assign a_blk_s = a_r[idx_r*BLK_W +: BLK_W];
  assign b_blk_s = b_r[idx_r*BLK_W +: BLK_W];

  csa_skip_block4 u_blk (
    .a4 (a_blk_s),
    .b4 (b_blk_s),
    .ci (carry_r),
    .s4 (s_blk_s),
    .co (co_blk_s),
    .bp (bp_blk_s)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          last_s      = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; in_ready is registered from the next state so it is low in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Operand capture and per-block accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      a_r     <= a;
      b_r     <= b;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= cin;
      cout_r  <= 1'b0;
    end else if (state_r == RUN) begin
      sum_r[idx_r*BLK_W +: BLK_W] <= s_blk_s;
      carry_r                     <= co_blk_s;
      if (last_s) begin
        idx_r       <= '0;
        cout_r      <= co_blk_s;
        out_valid_r <= 1'b1;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

`ifdef CSA_SKIP_STATS_EN
  localparam int SKW = $clog2(NBLK + 1);
  logic [SKW-1:0] skip_cnt_r;

  // Count blocks whose carry took the skip path in the current operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt_r <= '0;
    end else if (accept_s) begin
      skip_cnt_r <= '0;
    end else if (state_r == RUN) begin
      skip_cnt_r <= skip_cnt_r + SKW'(bp_blk_s);
    end else begin
      skip_cnt_r <= skip_cnt_r;
    end
  end

  assign skip_cnt = skip_cnt_r;
`endif

endmodule

// File: tb/tb_csa_serial_skip_adder.sv
// Self-checking bench: directed cases on a 16-bit adder, random traffic on 4/16/32-bit adders.
module tb_csa_serial_skip_adder;

  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Number of 4-bit blocks whose operand bits all differ.
  function automatic int exp_skips(input logic [63:0] x, input logic [63:0] y, input int w);
    int n;
    logic [63:0] p;
    n = 0;
    p = x ^ y;
    for (int i = 0; i < w / 4; i++) begin
      if (((p >> (4 * i)) & 64'hF) == 64'hF) n++;
    end
    return n;
  endfunction

  // ---------------- directed 16-bit DUT ----------------
  logic        d_iv, d_ir, d_cin, d_ov, d_or, d_cout;
  logic [15:0] d_a, d_b, d_sum;
`ifdef CSA_SKIP_STATS_EN
  logic [2:0]  d_sk;
`endif

  csa_serial_skip_adder #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_iv),
    .in_ready  (d_ir),
    .a         (d_a),
    .b         (d_b),
    .cin       (d_cin),
    .out_valid (d_ov),
    .out_ready (d_or),
    .sum       (d_sum),
    .cout      (d_cout)
`ifdef CSA_SKIP_STATS_EN
    ,
    .skip_cnt  (d_sk)
`endif
  );

  task automatic d_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input int hold, input bit pulse, input string tag);
    logic [16:0] exp;
    int t;
    exp = {1'b0, ta} + {1'b0, tb_v} + 17'(tc);
    @(negedge clk);
    d_a = ta; d_b = tb_v; d_cin = tc; d_iv = 1'b1;
    t = 0;
    while (!d_ir && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ready"}, 64'(d_ir), 64'd1);
    @(negedge clk);
    d_iv = pulse; d_a = ~ta; d_b = ta ^ 16'h5A5A; d_cin = ~tc;
    t = 0;
    while (!d_ov && t < 50) begin
      @(negedge clk);
      t++;
    end
    d_iv = 1'b0;
    check({tag, "_latency"}, 64'(t), 64'd4);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(d_ov), 64'd1);
      check({tag, "_hold_result"}, 64'({d_cout, d_sum}), 64'(exp));
      check({tag, "_hold_ready"}, 64'(d_ir), 64'd0);
    end
    check({tag, "_result"}, 64'({d_cout, d_sum}), 64'(exp));
`ifdef CSA_SKIP_STATS_EN
    check({tag, "_skips"}, 64'(d_sk), 64'(exp_skips(64'(ta), 64'(tb_v), 16)));
`endif
    d_or = 1'b1;
    @(negedge clk);
    d_or = 1'b0;
    check({tag, "_valid_cleared"}, 64'(d_ov), 64'd0);
    check({tag, "_ready_back"}, 64'(d_ir), 64'd1);
  endtask

  // ---------------- random DUTs: WIDTH 4, 16, 32 ----------------
  for (genvar k = 0; k < 3; k++) begin : g_rnd
    localparam int W  = (k == 0) ? 4 : ((k == 1) ? 16 : 32);
    localparam int NB = W / 4;
    logic         iv, ir, ci, ov, orr, co;
    logic [W-1:0] ra, rb, rs;
    bit           fin = 1'b0;
`ifdef CSA_SKIP_STATS_EN
    logic [$clog2(NB+1)-1:0] sk;
`endif

    csa_serial_skip_adder #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .cin       (ci),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (rs),
      .cout      (co)
`ifdef CSA_SKIP_STATS_EN
      ,
      .skip_cnt  (sk)
`endif
    );

    initial begin
      logic [W:0]   exp;
      logic [W-1:0] xa, xb;
      logic         xc;
      int           t;
      string        tg;
      iv = 1'b0; orr = 1'b0; ra = '0; rb = '0; ci = 1'b0;
      tg = $sformatf("rnd_w%0d", W);
      wait (go);
      for (int n = 0; n < N_RAND; n++) begin
        xa = W'($urandom);
        if ($urandom_range(3) == 0) begin
          xb = ~xa ^ (W'($urandom) & W'($urandom) & W'($urandom));
        end else begin
          xb = W'($urandom);
        end
        xc  = 1'($urandom_range(1));
        exp = {1'b0, xa} + {1'b0, xb} + (W+1)'(xc);
        repeat ($urandom_range(2)) @(negedge clk);
        ra = xa; rb = xb; ci = xc; iv = 1'b1;
        t = 0;
        while (!ir && t < 100) begin
          @(negedge clk);
          t++;
        end
        @(negedge clk);
        iv = 1'($urandom_range(1)); ra = W'($urandom); rb = W'($urandom); ci = ~xc;
        t = 0;
        while (!ov && t < 200) begin
          orr = 1'($urandom_range(1));
          @(negedge clk);
          t++;
        end
        iv = 1'b0;
        check({tg, "_latency"}, 64'(t), 64'(NB));
        check({tg, "_result"}, 64'({co, rs}), 64'(exp));
`ifdef CSA_SKIP_STATS_EN
        check({tg, "_skips"}, 64'(sk), 64'(exp_skips(64'(xa), 64'(xb), W)));
`endif
        while (!orr) begin
          @(negedge clk);
          check({tg, "_stall_result"}, 64'({ov, ir, co, rs}), 64'({2'b10, exp}));
          orr = 1'($urandom_range(1));
        end
        @(negedge clk);
        orr = 1'b0;
        check({tg, "_released"}, 64'(ov), 64'd0);
      end
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    int t;
    d_iv = 1'b0; d_or = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({d_ir, d_ov, d_cout, d_sum}), 64'd0);
`ifdef CSA_SKIP_STATS_EN
    check("reset_skips", 64'(d_sk), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", 64'(d_ir), 64'd1);

    d_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, "all_prop");
    d_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "no_skip");
    d_op(16'h8000, 16'h8000, 1'b0, 5, 1'b0, "stall5");

    // Abort an operation with reset in its second RUN cycle.
    @(negedge clk);
    d_a = 16'hABCD; d_b = 16'h1111; d_cin = 1'b0; d_iv = 1'b1;
    t = 0;
    while (!d_ir && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    d_iv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({d_ir, d_ov, d_cout, d_sum}), 64'd0);
`ifdef CSA_SKIP_STATS_EN
    check("abort_skips", 64'(d_sk), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (d_ov) seen++;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    d_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, "after_abort");
    d_op(16'h0F0F, 16'hF0F0, 1'b1, 2, 1'b1, "ignore_pulse");

    go = 1'b1;
    t = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check("rand_done", 64'({g_rnd[2].fin, g_rnd[1].fin, g_rnd[0].fin}), 64'd7);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
